// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
// Owner encoding is shared by the arbiter, the pipeline stages and the response steering.
package dmem_port_arbiter_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  typedef enum logic {
    ARB_OWN_A = 1'b0,
    ARB_OWN_B = 1'b1
  } arb_owner_e;

  // Round-robin hand-off: after a grant, the other requester gets priority.
  function automatic arb_owner_e other_owner(input arb_owner_e owner);
    return (owner == ARB_OWN_A) ? ARB_OWN_B : ARB_OWN_A;
  endfunction

  // One-hot grant vector to owner; only meaningful when a grant is present.
  function automatic arb_owner_e grant_owner(input logic [1:0] gnt);
    return gnt[1] ? ARB_OWN_B : ARB_OWN_A;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational one-hot grant and a registered priority pointer.
// Bit 0 is requester A, bit 1 is requester B; no grant is issued while reset is asserted.
module rr_arbiter2
  import dmem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  arb_owner_e ptr;
  arb_owner_e ptr_next;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gnt = 2'b00;
    if (reset) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr == ARB_OWN_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (|gnt) begin
      ptr_next = other_owner(grant_owner(gnt));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      ptr <= ARB_OWN_A;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares data-memory port 1 between requesters A and B: round-robin grant, registered issue
// stage S1 driving the memory, registered response stage S2 returning load data to its owner.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int DATA_W = DATA_LEN
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [1:0]        size_a,
  output logic              gnt_a,
  output logic              rvalid_a,

  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [1:0]        size_b,
  output logic              gnt_b,
  output logic              rvalid_b,

  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] mem_raddr,
  output logic [1:0]        mem_rsize,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wsize,
  output logic              mem_we
);

  typedef struct packed {
    logic              valid;
    logic              we;
    arb_owner_e        owner;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic [1:0] gnt;
  cmd_t       cmd_sel;
  cmd_t       s1;

  logic       s2_valid;
  arb_owner_e s2_owner;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req_b, req_a}),
    .gnt   (gnt)
  );

  assign gnt_a = gnt[0];
  assign gnt_b = gnt[1];

  // Granted command, ready to be captured into S1 at the end of the grant cycle.
  always_comb begin
    cmd_sel       = '0;
    cmd_sel.valid = |gnt;
    cmd_sel.owner = grant_owner(gnt);
    if (gnt[1]) begin
      cmd_sel.we    = we_b;
      cmd_sel.size  = size_b;
      cmd_sel.addr  = addr_b;
      cmd_sel.wdata = wdata_b;
    end else begin
      cmd_sel.we    = we_a;
      cmd_sel.size  = size_a;
      cmd_sel.addr  = addr_a;
      cmd_sel.wdata = wdata_a;
    end
  end

  // Issue stage: payload only moves on a grant, so the memory ports stay quiet while idle.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: payload flops are reset as well because the memory-side ports must read 0 during reset.
    if (!reset) begin
      s1 <= '0;
    end else if (|gnt) begin
      s1 <= cmd_sel;
    end else begin
      s1.valid <= 1'b0;
    end
  end

  assign mem_raddr = s1.addr;
  assign mem_rsize = s1.size;
  assign mem_waddr = s1.addr;
  assign mem_wsize = s1.size;
  assign mem_wdata = s1.wdata;
  assign mem_we    = s1.valid & s1.we;

  // Response stage: rdata is only loaded by a load, so it holds between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_owner <= ARB_OWN_A;
      rdata    <= '0;
    end else if (s1.valid && !s1.we) begin
      s2_valid <= 1'b1;
      s2_owner <= s1.owner;
      rdata    <= mem_rdata;
    end else begin
      s2_valid <= 1'b0;
    end
  end

  assign rvalid_a = s2_valid && (s2_owner == ARB_OWN_A);
  assign rvalid_b = s2_valid && (s2_owner == ARB_OWN_B);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed sequences, a grant table and random traffic,
// all compared against a transaction-level model (grant-order memory image plus a response queue).
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a, we_a, req_b, we_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [1:0]  size_a, size_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [31:0] rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [1:0]  mem_rsize, mem_wsize;
  logic        mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .size_a    (size_a),
    .gnt_a     (gnt_a),
    .rvalid_a  (rvalid_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .size_b    (size_b),
    .gnt_b     (gnt_b),
    .rvalid_b  (rvalid_b),
    .rdata     (rdata),
    .mem_raddr (mem_raddr),
    .mem_rsize (mem_rsize),
    .mem_rdata (mem_rdata),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wsize (mem_wsize),
    .mem_we    (mem_we)
  );

  // Memory behind port 1: combinational read, store committed at the clock edge.
  logic [31:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_raddr[9:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_waddr[9:2]] = mem_wdata;
  end

  // Reference model: memory updated in grant order, loads answered two cycles after their grant.
  typedef struct {
    logic        owner_b;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic [31:0] ref_mem [256];
  resp_t       rq [$];
  int          cyc = 0;
  logic        m_ptr_b;
  logic        e_v, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_size;
  logic [31:0] exp_rdata;
  logic        pend_v;
  logic [7:0]  pend_idx;
  logic [31:0] pend_old;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_inputs(input logic ra, input logic wa, input logic [31:0] aa, input logic [31:0] da,
                            input logic rb, input logic wb, input logic [31:0] ab, input logic [31:0] db);
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da; size_a = aa[1:0] ^ 2'b10;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; size_b = ab[1:0] ^ 2'b01;
  endtask

  task automatic idle();
    set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // A store granted in the cycle just before reset is still in flight and is dropped.
  task automatic model_reset();
    rq.delete();
    m_ptr_b   = 1'b0;
    e_v       = 1'b0;
    e_we      = 1'b0;
    exp_rdata = 32'h0;
    if (pend_v) ref_mem[pend_idx] = pend_old;
    pend_v = 1'b0;
  endtask

  // Checks one cycle at the falling edge, advances the model, returns 1 time unit after the next rising edge.
  task automatic do_cycle();
    logic        ga, gb, era, erb, w;
    logic [31:0] a, d;
    logic [1:0]  s;
    resp_t       r;
    @(negedge clk);
    ga = 1'b0;
    gb = 1'b0;
    if (reset) begin
      if (req_a && req_b) begin
        ga = !m_ptr_b;
        gb = m_ptr_b;
      end else begin
        ga = req_a;
        gb = req_b && !req_a;
      end
    end
    check("gnt_a", gnt_a, ga);
    check("gnt_b", gnt_b, gb);
    check("mem_we", mem_we, e_v & e_we);
    if (e_v) begin
      check("mem_raddr", mem_raddr, e_addr);
      check("mem_waddr", mem_waddr, e_addr);
      check("mem_rsize", mem_rsize, e_size);
      check("mem_wsize", mem_wsize, e_size);
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
    end
    if (!reset) begin
      check("rst_mem_raddr", mem_raddr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
    end
    era = 1'b0;
    erb = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      era       = !rq[0].owner_b;
      erb       = rq[0].owner_b;
      exp_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    check("rvalid_a", rvalid_a, era);
    check("rvalid_b", rvalid_b, erb);
    check("rdata", rdata, exp_rdata);

    pend_v = 1'b0;
    e_v    = ga | gb;
    if (ga | gb) begin
      w = gb ? we_b    : we_a;
      a = gb ? addr_b  : addr_a;
      d = gb ? wdata_b : wdata_a;
      s = gb ? size_b  : size_a;
      m_ptr_b = ga;
      e_we    = w;
      e_addr  = a;
      e_wdata = d;
      e_size  = s;
      if (w) begin
        pend_v   = 1'b1;
        pend_idx = a[9:2];
        pend_old = ref_mem[a[9:2]];
        ref_mem[a[9:2]] = d;
      end else begin
        r.owner_b = gb;
        r.data    = ref_mem[a[9:2]];
        r.due     = cyc + 2;
        rq.push_back(r);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  typedef struct {
    logic ra, wa, rb, wb;
    logic exp_ga, exp_gb;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] saved;
  int          diffs;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[8'h40]  = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    tb_mem[8'h80]  = 32'h0BAD_0BAD;
    ref_mem[8'h80] = 32'h0BAD_0BAD;
    pend_v = 1'b0;
    idle();
    model_reset();

    // Reset held while A requests: nothing granted or issued.
    set_inputs(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) do_cycle();
    check("rst_rvalid_a", rvalid_a, 1'b0);
    reset = 1'b1;
    #1;
    check("first_gnt_a", gnt_a, 1'b1);
    do_cycle();
    idle();
    repeat (3) do_cycle();

    // A-only load of 0x100.
    set_inputs(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    idle();
    do_cycle();
    check("t2_rvalid_a", rvalid_a, 1'b1);
    do_cycle();
    check("t2_rdata_hold", rdata, 32'hDEADBEEF);

    // Contention table: B alone sets priority to A, then four contended cycles alternate.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      set_inputs(tbl[i].ra, tbl[i].wa, 32'h40 + 32'(i * 4), $urandom,
                 tbl[i].rb, tbl[i].wb, 32'h80 + 32'(i * 4), $urandom);
      #1;
      check("tbl_gnt_a", gnt_a, tbl[i].exp_ga);
      check("tbl_gnt_b", gnt_b, tbl[i].exp_gb);
      do_cycle();
    end
    idle();
    repeat (3) do_cycle();

    // Store-then-load hazard on 0x200 across requesters.
    set_inputs(1'b1, 1'b1, 32'h200, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    check("hz_mem_we", mem_we, 1'b1);
    do_cycle();
    idle();
    repeat (2) do_cycle();
    check("hz_rdata", rdata, 32'h55);

    // Back-to-back loads from A.
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      do_cycle();
    end
    idle();
    repeat (3) do_cycle();

    // Store in flight when reset hits: memory must keep its old value, no response.
    saved = tb_mem[8'hC0];
    set_inputs(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    check("mf_mem_we", mem_we, 1'b0);
    repeat (2) do_cycle();
    reset = 1'b1;
    repeat (3) do_cycle();
    check("mf_mem_kept", tb_mem[8'hC0], saved);

    // Random mixed traffic.
    for (int i = 0; i < 3000; i++) begin
      set_inputs(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 {22'h0, 8'($urandom), 2'b00} | 32'($urandom_range(0, 3) << 30) & 32'h0, $urandom,
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                 {22'h0, 8'($urandom), 2'b00}, $urandom);
      do_cycle();
    end
    idle();
    repeat (4) do_cycle();

    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (tb_mem[i] !== ref_mem[i]) diffs++;
    end
    check("mem_image_diffs", 64'(diffs), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
